call_stack_rp: RTL and testbench

- Parametrised hardware return-address stack; successor to the fixed single-purpose stack feeding the PC source mux.
- Adds configurable depth and address width, two full-stack policies, sticky overflow/underflow error flags, and a one-level checkpoint/restore so the ID stage can undo speculative call/return activity when the pipeline flushes.
- Sits in stage 1 beside the controller; `top_addr` drives the PC mux "stack" input in the same cycle.

---
 rtl/call_stack_rp.sv | 157 +++++++++++++++
 tb/tb_call_stack_rp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_rp.sv
// call_stack_rp: parametrised return-address stack for the PC source mux.
// Circular storage with configurable full policy, sticky error flags and a
// one-level pointer/count checkpoint for undoing speculative call/return.
// Optional: define CALL_STACK_RP_WATERMARK_EN to add the max_depth output.
module call_stack_rp #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WRAP_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        push_addr,
    input  logic                         checkpoint,
    input  logic                         restore,
    input  logic                         err_clr,
    output logic [ADDR_WIDTH-1:0]        top_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
`ifdef CALL_STACK_RP_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   max_depth
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] snap_ptr_q, snap_ptr_d;
    logic [CW-1:0] snap_cnt_q, snap_cnt_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          ovf_set, unf_set;
    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [PW-1:0] top_ptr;
    logic          is_full, is_empty;

    assign top_ptr  = wr_ptr_q - PW'(1);
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // Next pointer/count, storage write and error events; restore beats push/pop
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (restore) begin
            wr_ptr_d = snap_ptr_q;
            count_d  = snap_cnt_q;
        end else if (push && pop && !is_empty) begin
            // Return immediately followed by call: replace top in place
            mem_we    = 1'b1;
            mem_waddr = top_ptr;
        end else if (push) begin
            if (!is_full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end else begin
                ovf_set = 1'b1;
                if (WRAP_MODE != 0) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
        end else if (pop) begin
            if (!is_empty) begin
                wr_ptr_d = wr_ptr_q - PW'(1);
                count_d  = count_q - CW'(1);
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    // Snapshot captures the post-update state; flags clear unless a new error arrives
    always_comb begin
        snap_ptr_d  = snap_ptr_q;
        snap_cnt_d  = snap_cnt_q;
        if (checkpoint && !restore) begin
            snap_ptr_d = wr_ptr_d;
            snap_cnt_d = count_d;
        end
        overflow_d  = err_clr ? ovf_set : (overflow_q | ovf_set);
        underflow_d = err_clr ? unf_set : (underflow_q | unf_set);
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            snap_ptr_q  <= '0;
            snap_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            snap_ptr_q  <= snap_ptr_d;
            snap_cnt_q  <= snap_cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately left unreset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= push_addr;
        end
    end

    assign top_addr  = is_empty ? '0 : mem[top_ptr];
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef CALL_STACK_RP_WATERMARK_EN
    logic [CW-1:0] max_q, max_d;

    // High-water mark of count; err_clr rebases it to the current depth
    always_comb begin
        if (err_clr) begin
            max_d = count_d;
        end else begin
            max_d = (count_d > max_q) ? count_d : max_q;
        end
    end

    // Watermark register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_depth = max_q;
`endif

endmodule

// File: tb/tb_call_stack_rp.sv
// Self-checking bench for call_stack_rp: two instances (drop and wrap policy)
// share stimulus and are compared against an array-based model of the stack.
module tb_call_stack_rp;

    localparam int AW = 12;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst;
    logic push, pop, checkpoint, restore, err_clr;
    logic [AW-1:0] push_addr;

    logic [AW-1:0] top_w   [2];
    logic [CW-1:0] cnt_w   [2];
    logic          full_w  [2];
    logic          empty_w [2];
    logic          ovf_w   [2];
    logic          unf_w   [2];
`ifdef CALL_STACK_RP_WATERMARK_EN
    logic [CW-1:0] max_w   [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = drop policy, 1 = wrap policy
    int m_mem [2][D];
    int m_ptr [2];
    int m_cnt [2];
    int m_sp  [2];
    int m_sc  [2];
    int m_max [2];
    bit m_ovf [2];
    bit m_unf [2];

    always #5 clk = ~clk;

    call_stack_rp #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_addr  (push_addr),
        .checkpoint (checkpoint),
        .restore    (restore),
        .err_clr    (err_clr),
        .top_addr   (top_w[0]),
        .count      (cnt_w[0]),
        .full       (full_w[0]),
        .empty      (empty_w[0]),
        .overflow   (ovf_w[0]),
        .underflow  (unf_w[0])
`ifdef CALL_STACK_RP_WATERMARK_EN
        ,
        .max_depth  (max_w[0])
`endif
    );

    call_stack_rp #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_addr  (push_addr),
        .checkpoint (checkpoint),
        .restore    (restore),
        .err_clr    (err_clr),
        .top_addr   (top_w[1]),
        .count      (cnt_w[1]),
        .full       (full_w[1]),
        .empty      (empty_w[1]),
        .overflow   (ovf_w[1]),
        .underflow  (unf_w[1])
`ifdef CALL_STACK_RP_WATERMARK_EN
        ,
        .max_depth  (max_w[1])
`endif
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_ptr[w] = 0; m_cnt[w] = 0; m_sp[w] = 0; m_sc[w] = 0;
            m_max[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
        end
    endtask

    function automatic int exp_top(input int w);
        return (m_cnt[w] > 0) ? m_mem[w][(m_ptr[w] + D - 1) % D] : 0;
    endfunction

    task automatic model_step(input int w, input bit pu, input bit po, input int a,
                              input bit ck, input bit rs, input bit ec);
        bit ov = 0;
        bit un = 0;
        if (rs) begin
            m_ptr[w] = m_sp[w];
            m_cnt[w] = m_sc[w];
        end else if (pu && po && m_cnt[w] > 0) begin
            m_mem[w][(m_ptr[w] + D - 1) % D] = a;
        end else if (pu) begin
            if (m_cnt[w] < D) begin
                m_mem[w][m_ptr[w]] = a;
                m_ptr[w] = (m_ptr[w] + 1) % D;
                m_cnt[w]++;
            end else begin
                ov = 1;
                if (w == 1) begin
                    m_mem[w][m_ptr[w]] = a;
                    m_ptr[w] = (m_ptr[w] + 1) % D;
                end
            end
        end else if (po) begin
            if (m_cnt[w] > 0) begin
                m_ptr[w] = (m_ptr[w] + D - 1) % D;
                m_cnt[w]--;
            end else begin
                un = 1;
            end
        end
        if (ck && !rs) begin
            m_sp[w] = m_ptr[w];
            m_sc[w] = m_cnt[w];
        end
        m_ovf[w] = ec ? ov : (m_ovf[w] | ov);
        m_unf[w] = ec ? un : (m_unf[w] | un);
        if (ec) m_max[w] = m_cnt[w];
        else if (m_cnt[w] > m_max[w]) m_max[w] = m_cnt[w];
    endtask

    task automatic check_all();
        for (int w = 0; w < 2; w++) begin
            check_eq($sformatf("w%0d top_addr", w), int'(top_w[w]), exp_top(w));
            check_eq($sformatf("w%0d count", w), int'(cnt_w[w]), m_cnt[w]);
            check_eq($sformatf("w%0d full", w), int'(full_w[w]), int'(m_cnt[w] == D));
            check_eq($sformatf("w%0d empty", w), int'(empty_w[w]), int'(m_cnt[w] == 0));
            check_eq($sformatf("w%0d overflow", w), int'(ovf_w[w]), int'(m_ovf[w]));
            check_eq($sformatf("w%0d underflow", w), int'(unf_w[w]), int'(m_unf[w]));
`ifdef CALL_STACK_RP_WATERMARK_EN
            check_eq($sformatf("w%0d max_depth", w), int'(max_w[w]), m_max[w]);
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model, check #1 after the edge
    task automatic step(input bit pu, input bit po, input int a,
                        input bit ck, input bit rs, input bit ec);
        push = pu; pop = po; push_addr = a[AW-1:0];
        checkpoint = ck; restore = rs; err_clr = ec;
        @(posedge clk);
        for (int w = 0; w < 2; w++) model_step(w, pu, po, a, ck, rs, ec);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        push = 0; pop = 0; push_addr = '0; checkpoint = 0; restore = 0; err_clr = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < D; i++) begin
            m_mem[0][i] = 0;
            m_mem[1][i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Basic push/pop
        step(1, 0, 'h010, 0, 0, 0);
        step(1, 0, 'h020, 0, 0, 0);
        step(1, 0, 'h030, 0, 0, 0);
        check_eq("lit count3", int'(cnt_w[0]), 3);
        check_eq("lit top030", int'(top_w[0]), 'h030);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        check_eq("lit empty", int'(empty_w[0]), 1);
        check_eq("lit top0", int'(top_w[0]), 0);

        // Fill past full: drop vs wrap
        for (int i = 0; i < 9; i++) step(1, 0, 'h100 + i, 0, 0, 0);
        check_eq("lit drop count", int'(cnt_w[0]), 8);
        check_eq("lit drop top", int'(top_w[0]), 'h107);
        check_eq("lit drop ovf", int'(ovf_w[0]), 1);
        check_eq("lit wrap top", int'(top_w[1]), 'h108);
        step(1, 0, 'h109, 0, 0, 0);
        check_eq("lit wrap top109", int'(top_w[1]), 'h109);
        check_eq("lit wrap count", int'(cnt_w[1]), 8);
        step(0, 0, 0, 0, 0, 1);
        check_eq("lit ovf clr", int'(ovf_w[0]), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
        check_eq("lit wrap drained", int'(empty_w[1]), 1);

        // Push+pop replace, then underflow
        step(1, 0, 'h010, 0, 0, 0);
        step(1, 0, 'h020, 0, 0, 0);
        step(1, 1, 'h055, 0, 0, 0);
        check_eq("lit replace count", int'(cnt_w[0]), 2);
        check_eq("lit replace top", int'(top_w[0]), 'h055);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check_eq("lit underflow", int'(unf_w[0]), 1);
        step(0, 0, 0, 0, 0, 1);

        // Checkpoint / restore
        step(1, 0, 'h010, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 'h020, 0, 0, 0);
        step(1, 0, 'h030, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("lit restore count", int'(cnt_w[0]), 1);
        check_eq("lit restore top", int'(top_w[0]), 'h010);
        step(1, 0, 'h077, 0, 1, 0);
        check_eq("lit restore+push", int'(top_w[0]), 'h010);

        // Asynchronous reset between edges with count=5
        for (int i = 0; i < 4; i++) step(1, 0, 'h200 + i, 0, 0, 0);
        check_eq("lit count5", int'(cnt_w[0]), 5);
        idle_inputs();
        @(posedge clk);
        for (int w = 0; w < 2; w++) model_step(w, 0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            bit pu = ($urandom_range(99) < 45);
            bit po = ($urandom_range(99) < 40);
            bit ck = ($urandom_range(99) < 8);
            bit rs = ($urandom_range(99) < 5);
            bit ec = ($urandom_range(99) < 5);
            step(pu, po, int'($urandom_range(4095)), ck, rs, ec);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
